// File: rtl/key_pulse_debouncer.sv
// rtl/key_pulse_debouncer.sv - push-button synchroniser, debouncer and press/release pulse generator
module key_pulse_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned    CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);
  // Level the synchroniser holds while the button is not pressed.
  localparam logic           REL_LVL = ACTIVE_LOW ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          s1_q;
  logic          s2_q;
  logic          pressed;

  // Only the second synchroniser stage is ever looked at by the FSM.
  assign pressed = ACTIVE_LOW ? ~s2_q : s2_q;

  // Two-flop synchroniser; resets to the released level so no false press appears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= REL_LVL;
      s2_q <= REL_LVL;
    end else begin
      s1_q <= key_raw;
      s2_q <= s1_q;
    end
  end

  // Debounce FSM: any opposite sample in a WAIT state restarts qualification.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pressed) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!pressed) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q     <= HELD;
            cnt_q       <= '0;
            press_pulse <= 1'b1;
            key_level   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        HELD: begin
          if (!pressed) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (pressed) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            release_pulse <= 1'b1;
            key_level     <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_pulse_debouncer.sv
// tb/tb_key_pulse_debouncer.sv - scoreboard bench for key_pulse_debouncer, both polarities
module tb_key_pulse_debouncer;

  localparam int DC = 4;
  localparam int LAT = DC + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_l = 1'b1;
  logic key_h = 1'b0;
  logic lvl_l, pp_l, rp_l;
  logic lvl_h, pp_h, rp_h;

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int cyc;
    bit press;
  } exp_t;

  exp_t q_l[$];
  exp_t q_h[$];

  key_pulse_debouncer #(.DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .rst(rst), .key_raw(key_l),
    .key_level(lvl_l), .press_pulse(pp_l), .release_pulse(rp_l)
  );

  key_pulse_debouncer #(.DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst(rst), .key_raw(key_h),
    .key_level(lvl_h), .press_pulse(pp_h), .release_pulse(rp_h)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, wanted %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int which, input int at, input bit press);
    exp_t e;
    e.cyc = at;
    e.press = press;
    if (which == 0) q_l.push_back(e);
    else q_h.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mon(input int which, input logic pp, input logic rp, input logic lvl);
    exp_t e;
    int qs;
    qs = (which == 0) ? q_l.size() : q_h.size();
    if (pp || rp) begin
      compared++;
      if (pp && rp) begin
        mismatched++;
        $display("FAIL both_pulses dut%0d: press and release high together at cycle %0d", which, cyc);
      end else if (qs == 0) begin
        mismatched++;
        $display("FAIL unexpected_pulse dut%0d: got %s pulse at cycle %0d, wanted none", which, pp ? "press" : "release", cyc);
      end else begin
        e = (which == 0) ? q_l.pop_front() : q_h.pop_front();
        if (e.cyc != cyc || e.press != pp || lvl != pp) begin
          mismatched++;
          $display("FAIL pulse dut%0d: got press=%0d cycle=%0d level=%0d, wanted press=%0d cycle=%0d level=%0d",
                   which, pp, cyc, lvl, e.press, e.cyc, e.press);
        end
      end
    end
  endtask

  // Monitor: sample both DUTs just after each rising edge and score any pulse.
  always begin
    @(posedge clk);
    #1;
    mon(0, pp_l, rp_l, lvl_l);
    mon(1, pp_h, rp_h, lvl_h);
  end

  initial begin
    int k;
    int r;
    // 1. reset
    rst = 1'b1; key_l = 1'b1; key_h = 1'b0;
    wait_cyc(3);
    chk("rst_level_l", lvl_l, 0);
    chk("rst_press_l", pp_l, 0);
    chk("rst_release_l", rp_l, 0);
    chk("rst_level_h", lvl_h, 0);
    rst = 1'b0;
    wait_cyc(20);
    chk("idle_level_l", lvl_l, 0);

    // 2. clean press
    k = cyc; key_l = 1'b0; push(0, k + LAT, 1'b1);
    wait_cyc(LAT - 1);
    chk("press_level_before", lvl_l, 0);
    wait_cyc(1);
    chk("press_level_at", lvl_l, 1);
    wait_cyc(13);
    chk("press_level_held", lvl_l, 1);

    // 4. clean release
    k = cyc; key_l = 1'b1; push(0, k + LAT, 1'b0);
    wait_cyc(LAT - 1);
    chk("release_level_before", lvl_l, 1);
    wait_cyc(1);
    chk("release_level_at", lvl_l, 0);
    wait_cyc(13);

    // 3. bouncing press
    for (int i = 0; i < 3; i++) begin
      key_l = 1'b0; wait_cyc(3);
      key_l = 1'b1; wait_cyc(1);
    end
    k = cyc; key_l = 1'b0; push(0, k + LAT, 1'b1);
    wait_cyc(20);
    chk("bounce_level", lvl_l, 1);

    // 4b. 2-cycle release glitch must be ignored
    key_l = 1'b1; wait_cyc(2);
    key_l = 1'b0; wait_cyc(20);
    chk("glitch_level", lvl_l, 1);
    k = cyc; key_l = 1'b1; push(0, k + LAT, 1'b0);
    wait_cyc(20);
    chk("glitch_release_level", lvl_l, 0);

    // 5. reset mid-qualification, then re-qualify after deassertion
    key_l = 1'b0; wait_cyc(4);
    rst = 1'b1; #1;
    chk("midrst_level", lvl_l, 0);
    chk("midrst_press", pp_l, 0);
    wait_cyc(3);
    r = cyc; rst = 1'b0; push(0, r + LAT, 1'b1);
    wait_cyc(20);
    chk("requal_level", lvl_l, 1);
    rst = 1'b1; #1;
    chk("async_clear_level", lvl_l, 0);
    chk("async_clear_release", rp_l, 0);
    wait_cyc(2);
    key_l = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(20);
    chk("post_rst_level", lvl_l, 0);

    // 6. active-high polarity
    k = cyc; key_h = 1'b1; push(1, k + LAT, 1'b1);
    wait_cyc(LAT - 1);
    chk("ah_level_before", lvl_h, 0);
    wait_cyc(1);
    chk("ah_level_at", lvl_h, 1);
    wait_cyc(13);
    k = cyc; key_h = 1'b0; push(1, k + LAT, 1'b0);
    wait_cyc(20);
    chk("ah_release_level", lvl_h, 0);

    chk("pending_l", q_l.size(), 0);
    chk("pending_h", q_h.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
